// File: rtl/pipeline_ctrl_pkg.sv
// Shared control-code encoding and bus types for the pipeline hazard/flow controller.
package pipeline_ctrl_pkg;

  typedef logic [1:0]  CTRL_Wire_Bus;
  typedef logic [31:0] AddrBus;

  localparam CTRL_Wire_Bus RUN   = 2'b00;
  localparam CTRL_Wire_Bus STALL = 2'b01;
  localparam CTRL_Wire_Bus FLUSH = 2'b10;
  localparam CTRL_Wire_Bus JUMP  = 2'b11;

  // Which hazard currently dominates, in decreasing priority.
  typedef enum logic [2:0] {
    CAUSE_RESET,
    CAUSE_MEM_BLOCK,
    CAUSE_EX_BLOCK,
    CAUSE_BRANCH,
    CAUSE_PENDING,
    CAUSE_DCACHE_BUSY,
    CAUSE_FETCH_WAIT,
    CAUSE_NONE
  } ctrl_cause_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Status/flag inputs and control-code outputs between the pipeline stages and the controller.
interface pipeline_ctrl_if #(
  parameter int ADDR_W = 32
);
  import pipeline_ctrl_pkg::*;

  logic              icache_ready_i;
  logic              muldiv_ready_i;
  logic              dcache_ready_i;
  logic [ADDR_W-1:0] ex_pc_new_i;
  logic              if_id_block_flag_i;
  logic              ex_branch_flag_i;
  logic              ex_block_flag_i;
  logic              mem_block_flag_i;

  CTRL_Wire_Bus      ctrl_signal_pc_o;
  CTRL_Wire_Bus      ctrl_signal_if_id_o;
  CTRL_Wire_Bus      ctrl_signal_id_ex_o;
  CTRL_Wire_Bus      ctrl_signal_muldiv_o;
  CTRL_Wire_Bus      ctrl_signal_ex_mem_o;
  CTRL_Wire_Bus      ctrl_signal_mem_wb_o;
  logic [ADDR_W-1:0] ctrl_to_pc_new_o;
  CTRL_Wire_Bus      ctrl_signal_icache_o;
  CTRL_Wire_Bus      ctrl_signal_dcache_o;

  // Pipeline side: reports hazards, consumes control codes.
  modport master (
    output icache_ready_i, muldiv_ready_i, dcache_ready_i, ex_pc_new_i,
           if_id_block_flag_i, ex_branch_flag_i, ex_block_flag_i, mem_block_flag_i,
    input  ctrl_signal_pc_o, ctrl_signal_if_id_o, ctrl_signal_id_ex_o,
           ctrl_signal_muldiv_o, ctrl_signal_ex_mem_o, ctrl_signal_mem_wb_o,
           ctrl_to_pc_new_o, ctrl_signal_icache_o, ctrl_signal_dcache_o
  );

  // Controller side.
  modport slave (
    input  icache_ready_i, muldiv_ready_i, dcache_ready_i, ex_pc_new_i,
           if_id_block_flag_i, ex_branch_flag_i, ex_block_flag_i, mem_block_flag_i,
    output ctrl_signal_pc_o, ctrl_signal_if_id_o, ctrl_signal_id_ex_o,
           ctrl_signal_muldiv_o, ctrl_signal_ex_mem_o, ctrl_signal_mem_wb_o,
           ctrl_to_pc_new_o, ctrl_signal_icache_o, ctrl_signal_dcache_o
  );

endinterface

// File: rtl/pipeline_ctrl.sv
// Priority hazard encoder for the five-stage pipeline, with a one-entry
// pending-redirect register for branches resolved while the I-cache is busy.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  ctrl_cause_e       cause;

  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;

  CTRL_Wire_Bus      pc_code, if_id_code, id_ex_code, muldiv_code;
  CTRL_Wire_Bus      ex_mem_code, mem_wb_code, icache_code, dcache_code;
  logic [ADDR_W-1:0] pc_target;

  logic              unused_muldiv_ready;
  assign unused_muldiv_ready = bus.muldiv_ready_i;

  always_comb begin
    cause = CAUSE_NONE;
    if (!rst)                                              cause = CAUSE_RESET;
    else if (bus.mem_block_flag_i)                         cause = CAUSE_MEM_BLOCK;
    else if (bus.ex_block_flag_i)                          cause = CAUSE_EX_BLOCK;
    else if (bus.ex_branch_flag_i)                         cause = CAUSE_BRANCH;
    else if (pend_valid_q)                                 cause = CAUSE_PENDING;
    else if (!bus.dcache_ready_i)                          cause = CAUSE_DCACHE_BUSY;
    else if (bus.if_id_block_flag_i || !bus.icache_ready_i) cause = CAUSE_FETCH_WAIT;
  end

  always_comb begin
    pc_code       = RUN;
    if_id_code    = RUN;
    id_ex_code    = RUN;
    muldiv_code   = RUN;
    ex_mem_code   = RUN;
    mem_wb_code   = RUN;
    icache_code   = RUN;
    dcache_code   = RUN;
    pc_target     = pend_valid_q ? pend_target_q : bus.ex_pc_new_i;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;

    unique case (cause)
      CAUSE_RESET: begin
        pc_code       = STALL;
        if_id_code    = FLUSH;
        id_ex_code    = FLUSH;
        muldiv_code   = FLUSH;
        ex_mem_code   = FLUSH;
        mem_wb_code   = FLUSH;
        icache_code   = FLUSH;
        dcache_code   = FLUSH;
        pc_target     = '0;
        pend_valid_d  = 1'b0;
        pend_target_d = '0;
      end
      CAUSE_MEM_BLOCK: begin
        pc_code     = STALL;
        if_id_code  = STALL;
        id_ex_code  = STALL;
        muldiv_code = STALL;
        ex_mem_code = STALL;
        icache_code = STALL;
        mem_wb_code = FLUSH;
      end
      CAUSE_EX_BLOCK: begin
        pc_code     = STALL;
        if_id_code  = STALL;
        id_ex_code  = STALL;
        icache_code = STALL;
        ex_mem_code = FLUSH;
      end
      CAUSE_BRANCH: begin
        if_id_code  = FLUSH;
        id_ex_code  = FLUSH;
        muldiv_code = FLUSH;
        icache_code = FLUSH;
        dcache_code = FLUSH;
        // A fresh branch supersedes any older pending target, whether it
        // jumps now or has to wait for the I-cache itself.
        if (bus.icache_ready_i) begin
          pc_code      = JUMP;
          pc_target    = bus.ex_pc_new_i;
          pend_valid_d = 1'b0;
        end else begin
          pc_code       = STALL;
          pend_valid_d  = 1'b1;
          pend_target_d = bus.ex_pc_new_i;
        end
      end
      CAUSE_PENDING: begin
        if_id_code = FLUSH;
        if (bus.icache_ready_i) begin
          pc_code      = JUMP;
          pend_valid_d = 1'b0;
        end else begin
          pc_code = STALL;
        end
      end
      CAUSE_DCACHE_BUSY: begin
        pc_code    = STALL;
        if_id_code = STALL;
        id_ex_code = FLUSH;
      end
      CAUSE_FETCH_WAIT: begin
        pc_code    = STALL;
        if_id_code = FLUSH;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign bus.ctrl_signal_pc_o     = pc_code;
  assign bus.ctrl_signal_if_id_o  = if_id_code;
  assign bus.ctrl_signal_id_ex_o  = id_ex_code;
  assign bus.ctrl_signal_muldiv_o = muldiv_code;
  assign bus.ctrl_signal_ex_mem_o = ex_mem_code;
  assign bus.ctrl_signal_mem_wb_o = mem_wb_code;
  assign bus.ctrl_to_pc_new_o     = pc_target;
  assign bus.ctrl_signal_icache_o = icache_code;
  assign bus.ctrl_signal_dcache_o = dcache_code;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed plus randomized bench for pipeline_ctrl against a queue-based
// reference model of the hazard priority rules.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int PC = 0, IFID = 1, IDEX = 2, MD = 3, EXMEM = 4, MEMWB = 5, IC = 6, DC = 7;

  typedef struct packed {
    logic        rst_n;
    logic        icr;
    logic        mdr;
    logic        dcr;
    logic [31:0] pc_new;
    logic        ifb;
    logic        br;
    logic        exb;
    logic        memb;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.ADDR_W(32)) bus ();

  pipeline_ctrl #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  logic [31:0] pend_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s        = '0;
    s.rst_n  = 1'b1;
    s.icr    = 1'b1;
    s.dcr    = 1'b1;
    s.mdr    = 1'b1;
    s.pc_new = $urandom;
    return s;
  endfunction

  task automatic run_cycle(input stim_t s);
    logic [1:0]  e[8];
    logic [1:0]  a[8];
    string       nm[8];
    logic [31:0] et;
    logic [31:0] nq[$];

    rst                    = s.rst_n;
    bus.icache_ready_i     = s.icr;
    bus.muldiv_ready_i     = s.mdr;
    bus.dcache_ready_i     = s.dcr;
    bus.ex_pc_new_i        = s.pc_new;
    bus.if_id_block_flag_i = s.ifb;
    bus.ex_branch_flag_i   = s.br;
    bus.ex_block_flag_i    = s.exb;
    bus.mem_block_flag_i   = s.memb;

    @(negedge clk);
    nq = pend_q;
    e  = '{default: RUN};
    et = (nq.size() != 0) ? nq[0] : s.pc_new;
    if (!s.rst_n) begin
      e     = '{default: FLUSH};
      e[PC] = STALL;
      et    = 32'h0;
      nq.delete();
    end else if (s.memb) begin
      e        = '{default: STALL};
      e[MEMWB] = FLUSH;
      e[DC]    = RUN;
    end else if (s.exb) begin
      e[PC] = STALL; e[IFID] = STALL; e[IDEX] = STALL; e[IC] = STALL;
      e[EXMEM] = FLUSH;
    end else if (s.br) begin
      e[IFID] = FLUSH; e[IDEX] = FLUSH; e[IC] = FLUSH; e[DC] = FLUSH; e[MD] = FLUSH;
      nq.delete();
      if (s.icr) begin
        e[PC] = JUMP;
        et    = s.pc_new;
      end else begin
        e[PC] = STALL;
        nq.push_back(s.pc_new);
      end
    end else if (nq.size() != 0) begin
      e[IFID] = FLUSH;
      if (s.icr) begin
        e[PC] = JUMP;
        et    = nq.pop_front();
      end else begin
        e[PC] = STALL;
      end
    end else if (!s.dcr) begin
      e[PC] = STALL; e[IFID] = STALL; e[IDEX] = FLUSH;
    end else if (s.ifb || !s.icr) begin
      e[PC] = STALL; e[IFID] = FLUSH;
    end

    a  = '{bus.ctrl_signal_pc_o, bus.ctrl_signal_if_id_o, bus.ctrl_signal_id_ex_o,
           bus.ctrl_signal_muldiv_o, bus.ctrl_signal_ex_mem_o, bus.ctrl_signal_mem_wb_o,
           bus.ctrl_signal_icache_o, bus.ctrl_signal_dcache_o};
    nm = '{"pc", "if_id", "id_ex", "muldiv", "ex_mem", "mem_wb", "icache", "dcache"};
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("c%0d %s", cyc, nm[i]), 32'(a[i]), 32'(e[i]));
    // The target only matters when the PC is told to load it, or under reset.
    if (e[PC] == JUMP || !s.rst_n)
      check_eq($sformatf("c%0d target", cyc), bus.ctrl_to_pc_new_o, et);

    @(posedge clk);
    #1;
    pend_q = nq;
    cyc++;
  endtask

  initial begin
    stim_t s;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset for two cycles, then one quiet cycle.
    s = idle(); s.rst_n = 1'b0;
    run_cycle(s);
    run_cycle(s);
    run_cycle(idle());

    // Branch with I-cache ready.
    s = idle(); s.br = 1'b1; s.pc_new = 32'h8000_0040;
    run_cycle(s);
    run_cycle(idle());

    // Branch with I-cache busy for three cycles, then accepted.
    s = idle(); s.br = 1'b1; s.pc_new = 32'h0000_0100; s.icr = 1'b0;
    run_cycle(s);
    s = idle(); s.icr = 1'b0;
    run_cycle(s);
    run_cycle(s);
    run_cycle(idle());
    run_cycle(idle());

    // MULDIV stall.
    s = idle(); s.exb = 1'b1; s.mdr = 1'b0;
    repeat (5) run_cycle(s);
    run_cycle(idle());

    // MEM stall plus branch while a redirect is pending.
    s = idle(); s.br = 1'b1; s.pc_new = 32'h0000_0200; s.icr = 1'b0;
    run_cycle(s);
    s = idle(); s.memb = 1'b1; s.br = 1'b1; s.pc_new = 32'h0000_0300;
    run_cycle(s);
    run_cycle(idle());
    run_cycle(idle());

    // Fetch miss, then D-cache busy.
    s = idle(); s.ifb = 1'b1;
    run_cycle(s);
    s = idle(); s.dcr = 1'b0;
    run_cycle(s);

    // Reset in the middle of a pending redirect: no JUMP afterwards.
    s = idle(); s.br = 1'b1; s.pc_new = 32'h0000_0400; s.icr = 1'b0;
    run_cycle(s);
    s = idle(); s.rst_n = 1'b0; s.icr = 1'b0;
    run_cycle(s);
    run_cycle(idle());

    // Randomized traffic with hazard-biased flags.
    repeat (800) begin
      s        = idle();
      s.rst_n  = ($urandom_range(0, 39) != 0);
      s.icr    = ($urandom_range(0, 9) < 7);
      s.dcr    = ($urandom_range(0, 9) < 8);
      s.mdr    = 1'($urandom);
      s.ifb    = ($urandom_range(0, 5) == 0);
      s.br     = ($urandom_range(0, 5) == 0);
      s.exb    = ($urandom_range(0, 7) == 0);
      s.memb   = ($urandom_range(0, 7) == 0);
      run_cycle(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and flow controller of the five-stage RV32 pipeline. Each cycle it collects block, branch and ready indications from IF_ID, EX, MEM, the multiplier/divider and both caches. It issues one 2-bit control code to the PC, to every pipeline register and to both caches. It also supplies the redirect target for the PC, including a one-entry pending-redirect register for branches resolved while the I-cache cannot accept a request.

## Interface
Parameters:
- `ADDR_W`, 32: PC/target width.
- Control code (`CTRL_Wire_Bus`, 2 bits), shared constants:
  - RUN = 2'b00
  - STALL = 2'b01 (hold contents)
  - FLUSH = 2'b10 (load bubble / cancel request)
  - JUMP = 2'b11 (PC only: load target)

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `icache_ready_i` in 1: I-cache can accept a fetch request.
- `muldiv_ready_i` in 1: MULDIV idle. Informational; it does not change any output.
- `dcache_ready_i` in 1: D-cache can accept a request.
- `ex_pc_new_i` in ADDR_W: branch/jump target from EX.
- `if_id_block_flag_i` in 1: fetched instruction not yet valid.
- `ex_branch_flag_i` in 1: EX resolved a taken branch/jump this cycle.
- `ex_block_flag_i` in 1: EX waiting on MULDIV result.
- `mem_block_flag_i` in 1: MEM waiting on load data.
- `ctrl_signal_pc_o` out 2: PC control.
- `ctrl_signal_if_id_o` out 2: IF_ID control.
- `ctrl_signal_id_ex_o` out 2: ID_EX control.
- `ctrl_signal_muldiv_o` out 2: MULDIV control.
- `ctrl_signal_ex_mem_o` out 2: EX_MEM control.
- `ctrl_signal_mem_wb_o` out 2: MEM_WB control.
- `ctrl_to_pc_new_o` out ADDR_W: PC redirect target, meaningful when the PC code is JUMP.
- `ctrl_signal_icache_o` out 2: I-cache control.
- `ctrl_signal_dcache_o` out 2: D-cache control.

## Operation
All outputs are combinational from the inputs and the pending register. Unless a rule below says otherwise, every output code is RUN. The first matching rule in this priority order applies:
1. `rst` low:
   - every stage register, muldiv, icache and dcache = FLUSH;
   - PC = STALL;
   - `ctrl_to_pc_new_o` = 0;
   - pending register cleared at the clock edge.
2. `mem_block_flag_i`:
   - PC, IF_ID, ID_EX, MULDIV, EX_MEM, icache = STALL;
   - MEM_WB = FLUSH;
   - dcache = RUN.
3. `ex_block_flag_i`:
   - PC, IF_ID, ID_EX, icache = STALL;
   - MULDIV = RUN;
   - EX_MEM = FLUSH;
   - MEM_WB = RUN.
4. `ex_branch_flag_i`:
   - IF_ID, ID_EX, icache, dcache, MULDIV = FLUSH (cancel wrong-path work);
   - if `icache_ready_i`: PC = JUMP, target = `ex_pc_new_i`;
   - otherwise: PC = STALL, and `ex_pc_new_i` is captured into the pending register (valid bit set).
5. Pending valid:
   - IF_ID = FLUSH;
   - if `icache_ready_i`: PC = JUMP with the pending target, valid cleared at the edge;
   - otherwise: PC = STALL and pending is kept.
6. `!dcache_ready_i`: PC, IF_ID = STALL; ID_EX = FLUSH.
7. `if_id_block_flag_i` or `!icache_ready_i`: PC = STALL; IF_ID = FLUSH.
8. Otherwise: all RUN.

Target and pending-register rules:
- `ctrl_to_pc_new_o` = pending target while pending is valid, else `ex_pc_new_i`.
- A new branch in rule 4 overwrites a valid pending entry; the younger target wins.
- The pending register is updated only in rules 4 and 5. It holds its value in rules 2 and 3.

## Timing
- Combinational input-to-output path: zero-cycle latency.
- Branch with the I-cache ready: JUMP in the same cycle. The PC holds the target after the next edge. IF_ID and ID_EX hold bubbles after that edge.
- Branch with the I-cache busy: JUMP is issued in the first cycle in which `icache_ready_i` = 1. The pending state lasts at most until then.
- Reset is synchronous. A reset in the middle of a pending redirect clears it at that edge; no JUMP follows.
- A MEM stall overrides a simultaneous branch. EX is frozen, so the branch is re-presented once the stall ends.

## Structure
- Shared package:
  - control code constants RUN/STALL/FLUSH/JUMP;
  - `CTRL_Wire_Bus` (2), `AddrBus` (32).
- Internals: one flat module. The priority encoder and the pending register (valid + 32-bit target) sit inline. No sub-module is needed.

## Test plan
- Reset: `rst` = 0 for 2 cycles → all stage codes FLUSH (2'b10), PC = 2'b01, target 0, pending cleared.
- Branch with the I-cache ready: `ex_branch_flag_i` = 1, `ex_pc_new_i` = 0x8000_0040, `icache_ready_i` = 1 → PC = JUMP, target 0x8000_0040, IF_ID/ID_EX/icache/dcache = FLUSH, EX_MEM/MEM_WB = RUN.
- Branch with the I-cache busy:
  - branch to 0x100 with `icache_ready_i` = 0 for 3 cycles → PC = STALL and IF_ID = FLUSH every cycle;
  - `icache_ready_i` = 1 on cycle 4 → PC = JUMP with target 0x100;
  - next cycle → all RUN.
- MULDIV stall: `ex_block_flag_i` = 1 for 5 cycles → PC/IF_ID/ID_EX = STALL, MULDIV = RUN, EX_MEM = FLUSH, MEM_WB = RUN; all RUN after it drops.
- MEM stall plus branch: `mem_block_flag_i` = 1 with `ex_branch_flag_i` = 1 → rule 2 outputs only, no JUMP, pending unchanged.
- Fetch miss: `if_id_block_flag_i` = 1 → PC = STALL, IF_ID = FLUSH, others RUN.
- D-cache busy: `dcache_ready_i` = 0 → PC/IF_ID = STALL, ID_EX = FLUSH.
